// File: rtl/uart_receiver.sv
// UART receive path: 16x-oversampled, start + 8 data LSB-first + optional even parity + stop.
// Strobes appear one clk after the mid-stop tick; no backpressure, and Rx_DATA holds until the next frame.
module uart_receiver #(
    parameter bit PARITY_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Rx_EN,
    input  logic       sample_ENABLE,
    input  logic       RxD,
    output logic [7:0] Rx_DATA,
    output logic       Rx_VALID,
    output logic       Rx_PERROR,
    output logic       Rx_FERROR
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t     state, state_nxt;
    logic [3:0] tick_cnt, tick_cnt_nxt;
    logic [2:0] bit_idx, bit_idx_nxt;
    logic [7:0] shift_reg, shift_nxt;
    logic       par_bit, par_nxt;
    logic [7:0] data_nxt;
    logic       valid_nxt, perr_nxt, ferr_nxt;
    logic       rxd_meta, rxd_s;
    logic       perr, ferr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            tick_cnt  <= 4'd0;
            bit_idx   <= 3'd0;
            shift_reg <= 8'h00;
            par_bit   <= 1'b0;
            rxd_meta  <= 1'b1;
            rxd_s     <= 1'b1;
            Rx_DATA   <= 8'h00;
            Rx_VALID  <= 1'b0;
            Rx_PERROR <= 1'b0;
            Rx_FERROR <= 1'b0;
        end else begin
            state     <= state_nxt;
            tick_cnt  <= tick_cnt_nxt;
            bit_idx   <= bit_idx_nxt;
            shift_reg <= shift_nxt;
            par_bit   <= par_nxt;
            rxd_meta  <= RxD;
            rxd_s     <= rxd_meta;
            Rx_DATA   <= data_nxt;
            Rx_VALID  <= valid_nxt;
            Rx_PERROR <= perr_nxt;
            Rx_FERROR <= ferr_nxt;
        end
    end

    // Frame checks, only consumed on the mid-stop tick.
    assign perr = PARITY_EN && (par_bit != ^shift_reg);
    assign ferr = !rxd_s;

    always_comb begin
        state_nxt    = state;
        tick_cnt_nxt = tick_cnt;
        bit_idx_nxt  = bit_idx;
        shift_nxt    = shift_reg;
        par_nxt      = par_bit;
        data_nxt     = Rx_DATA;
        valid_nxt    = 1'b0;
        perr_nxt     = 1'b0;
        ferr_nxt     = 1'b0;

        if (!Rx_EN) begin
            state_nxt    = IDLE;
            tick_cnt_nxt = 4'd0;
            bit_idx_nxt  = 3'd0;
        end else if (sample_ENABLE) begin
            case (state)
                IDLE: begin
                    if (!rxd_s) begin
                        state_nxt    = START;
                        tick_cnt_nxt = 4'd0;
                    end
                end
                START: begin
                    // Eighth tick after entry lands in the middle of the start bit.
                    if (tick_cnt == 4'd7) begin
                        tick_cnt_nxt = 4'd0;
                        bit_idx_nxt  = 3'd0;
                        state_nxt    = rxd_s ? IDLE : DATA;
                    end else begin
                        tick_cnt_nxt = tick_cnt + 4'd1;
                    end
                end
                DATA: begin
                    tick_cnt_nxt = tick_cnt + 4'd1;
                    if (tick_cnt == 4'd15) begin
                        shift_nxt   = {rxd_s, shift_reg[7:1]};
                        bit_idx_nxt = bit_idx + 3'd1;
                        if (bit_idx == 3'd7)
                            state_nxt = PARITY_EN ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    tick_cnt_nxt = tick_cnt + 4'd1;
                    if (tick_cnt == 4'd15) begin
                        par_nxt   = rxd_s;
                        state_nxt = STOP;
                    end
                end
                STOP: begin
                    tick_cnt_nxt = tick_cnt + 4'd1;
                    if (tick_cnt == 4'd15) begin
                        data_nxt     = shift_reg;
                        perr_nxt     = perr;
                        ferr_nxt     = ferr;
                        valid_nxt    = !perr && !ferr;
                        state_nxt    = IDLE;
                        tick_cnt_nxt = 4'd0;
                    end
                end
                default: begin
                    state_nxt    = IDLE;
                    tick_cnt_nxt = 4'd0;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- 8-bit UART receive path: 1 start bit, 8 data bits LSB-first, optional even parity bit, 1 stop bit.
- Recovers bytes from serial line RxD using the 16x-oversampling sample_ENABLE pulse from the baud controller.
- Delivers each byte with a one-cycle valid strobe or a parity/framing error strobe.
- Sits between the board pin / loopback TxD and the consuming logic, in parallel with the transmitter.

Parameters:
PARITY_EN, 1, 1 = frame carries even-parity bit after data bits; 0 = no parity bit, Rx_PERROR never asserts

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
Rx_EN  input  1  receiver enable; 0 forces IDLE and aborts any frame in progress
sample_ENABLE  input  1  one-clk pulse at 16x baud rate from baud controller
RxD  input  1  asynchronous serial input, idle high
Rx_DATA  output  8  last received byte, held until next frame completes
Rx_VALID  output  1  one-clk pulse: frame received with no error
Rx_PERROR  output  1  one-clk pulse: parity mismatch
Rx_FERROR  output  1  one-clk pulse: stop bit sampled low

Behaviour:
- Reset (synchronous, sampled on clk rising edge) dominates everything: state=IDLE, tick counter=0, bit index=0, shift register=0, synchronizer flops=1, Rx_DATA=8'h00, Rx_VALID=Rx_PERROR=Rx_FERROR=0.
- RxD passes through a 2-flop synchronizer (reset value 1). All decisions use the synchronized value RxD_s.
- State advances only on clk edges where sample_ENABLE=1 ("ticks"). Between ticks all state holds.
- Rx_EN=0: next edge goes to IDLE and clears the counters. No strobes are produced. Rx_DATA holds.
- States:
  - IDLE: on a tick with RxD_s=0 -> START, tick counter=0.
  - START: tick counter increments per tick. On the 8th tick after entry (mid start bit), RxD_s=0 -> DATA with counter=0 and bit index=0. RxD_s=1 -> glitch, back to IDLE, no strobe.
  - DATA: counter increments per tick. On every 16th tick (counter wraps 15->0), RxD_s is shifted in LSB-first. After bit index 7 is captured -> PARITY if PARITY_EN, else STOP.
  - PARITY: on the 16th tick, capture the parity bit -> STOP.
  - STOP: on the 16th tick (mid stop bit), evaluate the frame and return to IDLE.
- STOP evaluation, on that same tick edge:
  - Rx_DATA <= assembled byte, regardless of error.
  - perr = PARITY_EN and (captured parity != XOR of the 8 data bits).
  - ferr = (RxD_s == 0).
  - Rx_PERROR <= perr; Rx_FERROR <= ferr; Rx_VALID <= !perr && !ferr.
  - All three strobes are 1 clk wide and cleared on the next clk edge, independent of sample_ENABLE.
- Latency: the strobes are visible in the clk cycle after the mid-stop tick edge. Frame length is 16*(10+PARITY_EN) ticks nominal.
- Back-to-back frames: after the mid-stop evaluation, the receiver is in IDLE and detects a start edge on the next tick.
- If a start bit follows a framing error with RxD still low, the next tick may enter START. A false start is rejected at mid-bit as above.
- sample_ENABLE coincident with reset: reset wins.
- sample_ENABLE coincident with Rx_EN=0: abort wins.
- No 4-bit counter overflow beyond the 15->0 wrap; the bit index saturates by state exit.

Test Plan:
- Basic frame: sample_ENABLE every 4 clks, PARITY_EN=1. Send 0xA5 (bits 1,0,1,0,0,1,0,1), parity 0, stop 1 -> one Rx_VALID pulse, Rx_DATA=0xA5, no error strobes.
- Parity error: send 0xA5 with parity bit 1 -> Rx_PERROR pulse, Rx_VALID=0, Rx_DATA=0xA5.
- Framing error: send 0x3C, parity 0, stop bit 0 -> Rx_FERROR pulse, Rx_VALID=0, Rx_DATA=0x3C.
- Glitch rejection: drive RxD low for 4 ticks, then high -> returns to IDLE, no strobes, Rx_DATA unchanged.
- Back-to-back frames: 0x00 (parity 0) immediately followed by 0xFF (parity 0) -> two Rx_VALID pulses, Rx_DATA 0x00 then 0xFF.
- Abort: assert reset mid-data-bit 3 -> all outputs 0 on next edge. Separately, drop Rx_EN mid-frame -> no strobe, then re-enable and send 0x5A -> Rx_VALID, Rx_DATA=0x5A.
